// File: rtl/fetch_unit.sv
// Instruction-fetch and program-counter sequencer.
// Fetches one instruction word at a time from instruction memory, presents it
// to the decoder, and on acceptance computes the next PC from the decoder's
// PC control fields, the ALU branch result and the RS register value.
// A STOP or a misaligned register-jump target parks the core in HALT until reset.
//
// Optional feature: define FETCH_INSTRET_EN to build the retired-instruction
// counter on instret; otherwise instret is tied to zero.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   // instruction memory
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   // decoder interface
   output logic [31:0] ins,
   output logic        ins_valid,
   input  logic        ins_accept,
   input  logic [1:0]  pc_inc,
   input  logic        pc_jump,
   input  logic        branch_taken,
   input  logic [31:0] reg_data,
   // status
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        halted,
   output logic        fault,
   output logic [31:0] instret
);

   typedef enum logic [1:0] {
      StFetch,
      StIssue,
      StHalt
   } state_e;

   localparam logic [1:0] PcStop   = 2'b00;
   localparam logic [1:0] PcNormal = 2'b01;
   localparam logic [1:0] PcBranch = 2'b10;
   localparam logic [1:0] PcJump   = 2'b11;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ins_q, ins_d;
   logic        halted_q, halted_d;
   logic        fault_q, fault_d;

   logic [31:0] pc_plus4_w;
   logic [31:0] branch_target;
   logic [31:0] jump_target;
   logic        reg_misaligned;

   assign pc_plus4_w = pc_q + 32'd4;
   // Word offset from the 16-bit immediate, relative to pc+4.
   assign branch_target = pc_plus4_w + {{14{ins_q[15]}}, ins_q[15:0], 2'b00};
   // Region-relative absolute jump: keep the top nibble of pc+4.
   assign jump_target = {pc_plus4_w[31:28], ins_q[25:0], 2'b00};
   assign reg_misaligned = (reg_data[1:0] != 2'b00);

   // Next-state logic: fetch handshake, PC selection on accept, halt/fault capture.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ins_d    = ins_q;
      halted_d = halted_q;
      fault_d  = fault_q;
      unique case (state_q)
         StFetch: begin
            if (imem_ready) begin
               ins_d   = imem_rdata;
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (ins_accept) begin
               unique case (pc_inc)
                  PcNormal: begin
                     pc_d    = pc_plus4_w;
                     state_d = StFetch;
                  end
                  PcBranch: begin
                     pc_d    = branch_taken ? branch_target : pc_plus4_w;
                     state_d = StFetch;
                  end
                  PcJump: begin
                     if (!pc_jump) begin
                        pc_d    = jump_target;
                        state_d = StFetch;
                     end else if (!reg_misaligned) begin
                        pc_d    = reg_data;
                        state_d = StFetch;
                     end else begin
                        // Leave pc on the offending instruction for post-mortem.
                        fault_d  = 1'b1;
                        halted_d = 1'b1;
                        state_d  = StHalt;
                     end
                  end
                  PcStop: begin
                     halted_d = 1'b1;
                     state_d  = StHalt;
                  end
                  default: begin
                     state_d = StHalt;
                  end
               endcase
            end
         end
         StHalt: begin
            state_d = StHalt;
         end
         default: begin
            state_d = StHalt;
         end
      endcase
   end

   // Architectural state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StFetch;
         pc_q     <= RESET_PC;
         ins_q    <= 32'h0;
         halted_q <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ins_q    <= ins_d;
         halted_q <= halted_d;
         fault_q  <= fault_d;
      end
   end

`ifdef FETCH_INSTRET_EN
   logic [31:0] instret_q, instret_d;
   logic        retire;

   // A STOP retires; a faulting register jump does not.
   assign retire = (state_q == StIssue) && ins_accept &&
                   !((pc_inc == PcJump) && pc_jump && reg_misaligned);

   // Retired-instruction counter, wraps at 2^32.
   always_comb begin
      instret_d = instret_q;
      if (retire) begin
         instret_d = instret_q + 32'd1;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         instret_q <= 32'h0;
      end else begin
         instret_q <= instret_d;
      end
   end

   assign instret = instret_q;
`else
   assign instret = 32'h0;
`endif

   assign imem_req  = (state_q == StFetch);
   assign imem_addr = pc_q;
   assign ins       = ins_q;
   assign ins_valid = (state_q == StIssue);
   assign pc        = pc_q;
   assign pc_plus4  = pc_plus4_w;
   assign halted    = halted_q;
   assign fault     = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a vector table walked through the
// fetch/issue loop, with the expected next fetch address queued on each accept
// and popped when the DUT next requests memory, plus hand-written sequences
// for fault, stall/STOP, reset corner cases and PC wrap.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req, imem_ready;
   logic [31:0] imem_addr, imem_rdata;
   logic [31:0] ins, pc, pc_plus4, instret, reg_data;
   logic        ins_valid, ins_accept, pc_jump, branch_taken, halted, fault;
   logic [1:0]  pc_inc;

   // Second instance at the top of the address space, sharing all inputs.
   logic        w_imem_req, w_ins_valid, w_halted, w_fault;
   logic [31:0] w_imem_addr, w_ins, w_pc, w_pc_plus4, w_instret;

`ifdef FETCH_INSTRET_EN
   localparam bit InstretEn = 1'b1;
`else
   localparam bit InstretEn = 1'b0;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic [31:0] word;
      logic [1:0]  inc;
      logic        jmp;
      logic        taken;
      logic [31:0] rs;
      logic [31:0] pc;
      logic [31:0] nxt;
   } vec_t;

   vec_t vecs[12];

   fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rdata(imem_rdata), .ins(ins), .ins_valid(ins_valid), .ins_accept(ins_accept),
      .pc_inc(pc_inc), .pc_jump(pc_jump), .branch_taken(branch_taken), .reg_data(reg_data),
      .pc(pc), .pc_plus4(pc_plus4), .halted(halted), .fault(fault), .instret(instret)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .rst(rst),
      .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ready(imem_ready),
      .imem_rdata(imem_rdata), .ins(w_ins), .ins_valid(w_ins_valid), .ins_accept(ins_accept),
      .pc_inc(pc_inc), .pc_jump(pc_jump), .branch_taken(branch_taken), .reg_data(reg_data),
      .pc(w_pc), .pc_plus4(w_pc_plus4), .halted(w_halted), .fault(w_fault),
      .instret(w_instret)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Synchronous reset pulse; leaves the bench at a negedge with state FETCH.
   task automatic do_reset();
      rst = 1'b1;
      ins_accept = 1'b0;
      imem_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      exp_q.push_back(32'h0000_0000);
   endtask

   // Wait (bounded) for a request, check address against the scoreboard, return word.
   task automatic fetch(input logic [31:0] word);
      logic [31:0] e;
      int n = 0;
      while (!imem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("fetch_req", {31'b0, imem_req}, 32'd1);
      check("fetch_no_issue", {31'b0, ins_valid}, 32'd0);
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         check("fetch_addr", imem_addr, e);
      end
      imem_ready = 1'b1;
      imem_rdata = word;
      @(negedge clk);
      imem_ready = 1'b0;
      imem_rdata = $urandom;
   endtask

   task automatic accept(input logic [1:0] inc, input logic jmp, input logic taken,
                         input logic [31:0] rs, input logic push, input logic [31:0] nxt);
      check("issue_valid", {31'b0, ins_valid}, 32'd1);
      pc_inc = inc;
      pc_jump = jmp;
      branch_taken = taken;
      reg_data = rs;
      ins_accept = 1'b1;
      @(negedge clk);
      ins_accept = 1'b0;
      if (push) exp_q.push_back(nxt);
   endtask

   initial begin
      logic [31:0] hold_addr;
      //          word          inc    jmp   tkn   rs             pc             next
      vecs[0]  = '{32'h2000_0001, 2'b01, 1'b0, 1'b0, 32'h0,         32'h0,         32'h4};
      vecs[1]  = '{32'h2000_0002, 2'b01, 1'b0, 1'b0, 32'h0,         32'h4,         32'h8};
      vecs[2]  = '{32'h2000_0003, 2'b01, 1'b0, 1'b0, 32'h0,         32'h8,         32'hC};
      vecs[3]  = '{32'h2000_0004, 2'b01, 1'b0, 1'b0, 32'h0,         32'hC,         32'h10};
      vecs[4]  = '{32'h1000_FFFC, 2'b10, 1'b0, 1'b1, 32'h0,         32'h10,        32'h4};
      vecs[5]  = '{32'h0000_0008, 2'b11, 1'b1, 1'b0, 32'h10,        32'h4,         32'h10};
      vecs[6]  = '{32'h1400_FFFC, 2'b10, 1'b0, 1'b0, 32'h0,         32'h10,        32'h14};
      vecs[7]  = '{32'h0000_0008, 2'b11, 1'b1, 1'b0, 32'h9000_0040, 32'h14,        32'h9000_0040};
      vecs[8]  = '{32'h0800_0100, 2'b11, 1'b0, 1'b0, 32'h0,         32'h9000_0040, 32'h9000_0400};
      vecs[9]  = '{32'h0000_0008, 2'b11, 1'b1, 1'b0, 32'h2000,      32'h9000_0400, 32'h2000};
      vecs[10] = '{32'h1000_7FFF, 2'b10, 1'b0, 1'b1, 32'h0,         32'h2000,      32'h22000};
      vecs[11] = '{32'h2000_000C, 2'b01, 1'b0, 1'b0, 32'h0,         32'h22000,     32'h22004};

      rst = 1'b1;
      imem_ready = 1'b0;
      imem_rdata = 32'h0;
      ins_accept = 1'b0;
      pc_inc = 2'b00;
      pc_jump = 1'b0;
      branch_taken = 1'b0;
      reg_data = 32'h0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back(32'h0000_0000);

      // Reset state
      check("rst_pc", pc, 32'h0);
      check("rst_ins", ins, 32'h0);
      check("rst_halted", {31'b0, halted}, 32'd0);
      check("rst_fault", {31'b0, fault}, 32'd0);
      check("rst_instret", instret, 32'h0);

      // Table: fetch, check issue view, accept, queue next fetch address
      for (int i = 0; i < 12; i++) begin
         fetch(vecs[i].word);
         check("issue_pc", pc, vecs[i].pc);
         check("issue_ins", ins, vecs[i].word);
         check("issue_pc_plus4", pc_plus4, vecs[i].pc + 32'd4);
         check("issue_instret", instret, InstretEn ? i : 32'd0);
         accept(vecs[i].inc, vecs[i].jmp, vecs[i].taken, vecs[i].rs, 1'b1, vecs[i].nxt);
      end

      // Misaligned register jump: fault and halt, stray pulses ignored
      fetch(32'h0000_0008);
      accept(2'b11, 1'b1, 1'b0, 32'h0000_2002, 1'b0, 32'h0);
      for (int i = 0; i < 12; i++) begin
         check("flt_req", {31'b0, imem_req}, 32'd0);
         check("flt_valid", {31'b0, ins_valid}, 32'd0);
         check("flt_halted", {31'b0, halted}, 32'd1);
         check("flt_fault", {31'b0, fault}, 32'd1);
         check("flt_pc", pc, 32'h22004);
         ins_accept = 1'($urandom);
         imem_ready = 1'($urandom);
         pc_inc = 2'b01;
         @(negedge clk);
      end
      check("flt_instret", instret, InstretEn ? 32'd12 : 32'd0);
      do_reset();
      check("flt_rst_pc", imem_addr, 32'h0);
      check("flt_rst_fault", {31'b0, fault}, 32'd0);
      check("flt_rst_halted", {31'b0, halted}, 32'd0);
      check("flt_rst_instret", instret, 32'h0);

      // Fetch stall then STOP
      hold_addr = imem_addr;
      for (int i = 0; i < 5; i++) begin
         imem_rdata = $urandom;
         @(negedge clk);
         check("stall_req", {31'b0, imem_req}, 32'd1);
         check("stall_addr", imem_addr, hold_addr);
         check("stall_valid", {31'b0, ins_valid}, 32'd0);
      end
      fetch(32'h2000_0001);
      accept(2'b01, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4);
      fetch(32'h0000_0000);
      accept(2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      for (int i = 0; i < 6; i++) begin
         check("stop_halted", {31'b0, halted}, 32'd1);
         check("stop_fault", {31'b0, fault}, 32'd0);
         check("stop_valid", {31'b0, ins_valid}, 32'd0);
         check("stop_req", {31'b0, imem_req}, 32'd0);
         check("stop_pc", pc, 32'h4);
         ins_accept = 1'($urandom);
         imem_ready = 1'($urandom);
         @(negedge clk);
      end
      check("stop_instret", instret, InstretEn ? 32'd2 : 32'd0);

      // Reset during a stalled FETCH
      do_reset();
      fetch(32'h2000_0001);
      accept(2'b01, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4);
      check("midf_addr_before", imem_addr, 32'h4);
      do_reset();
      check("midf_addr", imem_addr, 32'h0);
      check("midf_ins", ins, 32'h0);
      check("midf_instret", instret, 32'h0);
      check("midf_req", {31'b0, imem_req}, 32'd1);

      // rst and ins_accept together: reset wins
      fetch(32'h2000_0001);
      rst = 1'b1;
      ins_accept = 1'b1;
      pc_inc = 2'b00;
      @(negedge clk);
      rst = 1'b0;
      ins_accept = 1'b0;
      exp_q.delete();
      exp_q.push_back(32'h0);
      check("rwin_halted", {31'b0, halted}, 32'd0);
      check("rwin_pc", pc, 32'h0);
      check("rwin_req", {31'b0, imem_req}, 32'd1);

      // PC wrap from 0xFFFF_FFFC
      do_reset();
      check("wrap_rst_addr", w_imem_addr, 32'hFFFF_FFFC);
      check("wrap_plus4", w_pc_plus4, 32'h0);
      fetch(32'h2000_0001);
      accept(2'b01, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4);
      check("wrap_addr", w_imem_addr, 32'h0);
      check("wrap_req", {31'b0, w_imem_req}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch and program-counter sequencer. Supplies the 32-bit instruction word to the combinational control decoder.
- Consumes the decoder's PC control fields (PC_INC, PC_JUMP) together with the ALU branch result and the RS register value, and computes the next PC.
- Sits between instruction memory and the decode/execute datapath. Owns the PC register and the halt/fault state of the core.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be word-aligned (bits [1:0] = 00).

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address; equals pc
- imem_ready  in  1  imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction word
- ins  out  32  registered instruction presented to decoder
- ins_valid  out  1  ins holds an un-retired instruction
- ins_accept  in  1  decode/execute consumes ins this cycle; control inputs valid
- pc_inc  in  2  00 STOP, 01 NORMAL, 10 BRANCH, 11 JUMP
- pc_jump  in  1  0 IMME (26-bit target), 1 REG (rs value)
- branch_taken  in  1  ALU branch condition result (BEQ/BNE)
- reg_data  in  32  RS read data, used for REG jumps
- pc  out  32  address of current instruction
- pc_plus4  out  32  pc + 4; return address for JAL
- halted  out  1  core stopped
- fault  out  1  stopped due to misaligned REG jump target
- instret  out  32  retired-instruction count (see Optional Feature)

Behaviour:
- Reset (rst=1 at clk edge):
  - pc <= RESET_PC; state <= FETCH; ins <= 0.
  - ins_valid, halted, fault, instret <= 0.
  - Any outstanding imem request is abandoned with no retry bookkeeping.
  - Reset mid-operation (any state) has the same effect.
- States: FETCH, ISSUE, HALT.
- FETCH:
  - imem_req=1, imem_addr=pc, held stable until imem_ready.
  - On imem_ready: ins <= imem_rdata, go to ISSUE.
  - While imem_ready=0: remain in FETCH with no change.
- ISSUE:
  - ins_valid=1, imem_req=0.
  - ins_accept=0: hold ins, pc and state.
  - On ins_accept=1, evaluate pc_inc in that same cycle:
    - NORMAL: pc <= pc+4, go to FETCH.
    - BRANCH: pc <= branch_taken ? pc+4+(sext(ins[15:0])<<2) : pc+4, go to FETCH.
    - JUMP, pc_jump=0: pc <= {pc_plus4[31:28], ins[25:0], 2'b00}, go to FETCH.
    - JUMP, pc_jump=1, reg_data[1:0]==00: pc <= reg_data, go to FETCH.
    - JUMP, pc_jump=1, reg_data[1:0]!=00: pc unchanged, fault<=1, halted<=1, go to HALT.
    - STOP: pc unchanged, halted<=1, go to HALT.
- HALT:
  - imem_req=0, ins_valid=0.
  - Absorbing state; exited only by rst.
  - halted and fault stay asserted.
- Outputs:
  - ins_valid=1 exactly when state is ISSUE.
  - pc_plus4 is combinational pc+4.
- Arithmetic: all modulo 2^32. pc 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000. Branch target arithmetic wraps likewise.
- pc[1:0] is always 00 outside reset.
- Throughput: minimum 2 cycles per instruction (imem_ready in the FETCH cycle, ins_accept in the ISSUE cycle).
- imem_ready while not in FETCH is ignored. ins_accept outside ISSUE is ignored.
- Simultaneous rst and ins_accept: rst wins.
- A STOP counts as retired; a fault-causing JUMP does not.

Optional Feature:
- Macro: FETCH_INSTRET_EN.
- Defined:
  - instret increments by 1 on each ISSUE-state ins_accept, except when that acceptance raises fault.
  - Cleared by rst; wraps at 2^32.
- Undefined:
  - instret tied to 32'h0; no counter register synthesized.
  - All other behaviour identical.

Test Plan:
- Reset, imem_ready=1 always, three NORMAL accepts → imem_addr 0x0,0x4,0x8 in successive FETCH cycles; ins_valid high every 2nd cycle; pc_plus4=0xC at third ISSUE.
- BRANCH at pc=0x10, ins[15:0]=16'hFFFC:
  - branch_taken=1 → next imem_addr=0x4.
  - Repeat with branch_taken=0 → next imem_addr=0x14.
- JUMP at pc=0x9000_0040:
  - pc_jump=0, ins[25:0]=26'h0000100 → imem_addr=0x9000_0400.
  - pc_jump=1, reg_data=0x0000_2000 → imem_addr=0x2000.
- pc_jump=1, reg_data=0x0000_2002 → fault=1, halted=1, pc stays at issuing address, imem_req stays 0 for 10+ cycles; rst then restarts at RESET_PC with fault=0.
- Fetch stall and STOP:
  - imem_ready low 5 cycles → imem_req/imem_addr stable, no ISSUE.
  - Then STOP accept → halted=1, ins_valid=0, further ins_accept/imem_ready pulses ignored.
  - With FETCH_INSTRET_EN, instret=number of accepts including STOP.
- Wrap and reset: RESET_PC=0xFFFF_FFFC, NORMAL accept → imem_addr 0x0.
- Reset mid-FETCH: rst asserted during a FETCH with imem_ready=0 → next cycle imem_addr=RESET_PC, ins=0, instret=0.
